// File: rtl/calc_pkg.sv
// Shared types for the calculator engine: FSM states, key codes, ASCII glyphs
// and the keypad-position decode.
package calc_pkg;

  typedef enum logic [1:0] {S_OPA, S_OPB, S_EXEC, S_DONE} state_e;

  typedef enum logic [3:0] {
    K_0, K_1, K_2, K_3, K_4, K_5, K_6, K_7, K_8, K_9,
    K_ADD, K_SUB, K_MUL, K_CLR, K_EQ, K_BLANK
  } key_e;

  localparam logic [7:0] CH_0   = "0";
  localparam logic [7:0] CH_ADD = "+";
  localparam logic [7:0] CH_SUB = "-";
  localparam logic [7:0] CH_MUL = "*";
  localparam logic [7:0] CH_DIV = "/";
  localparam logic [7:0] CH_EQ  = "=";
  localparam logic [7:0] CH_CLR = "C";

  function automatic key_e key_at(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'h0:    key_at = K_1;
      4'h1:    key_at = K_2;
      4'h2:    key_at = K_3;
      4'h3:    key_at = K_ADD;
      4'h4:    key_at = K_4;
      4'h5:    key_at = K_5;
      4'h6:    key_at = K_6;
      4'h7:    key_at = K_SUB;
      4'h8:    key_at = K_7;
      4'h9:    key_at = K_8;
      4'hA:    key_at = K_9;
      4'hB:    key_at = K_MUL;
      4'hC:    key_at = K_CLR;
      4'hD:    key_at = K_0;
      4'hE:    key_at = K_EQ;
      default: key_at = K_BLANK;
    endcase
  endfunction

  // The blank key carries the divide glyph; whether it acts as an operator is decided by the core.
  function automatic logic [7:0] key_char(input key_e k);
    if (k <= K_9) begin
      key_char = CH_0 + {4'h0, k};
    end else begin
      case (k)
        K_ADD:   key_char = CH_ADD;
        K_SUB:   key_char = CH_SUB;
        K_MUL:   key_char = CH_MUL;
        K_CLR:   key_char = CH_CLR;
        K_EQ:    key_char = CH_EQ;
        default: key_char = CH_DIV;
      endcase
    end
  endfunction

endpackage

// File: rtl/calc_if.sv
// Keypad-pulse inputs and display-side outputs of the calculator engine.
interface calc_if #(parameter int DW = 16);
  logic          key_up, key_down, key_left, key_right, key_ok;
  logic [3:0]    cursor_x, cursor_y;
  logic [15:0]   input_val;
  logic [DW-1:0] result;
  logic [7:0]    op_char;
  logic          calc_done, busy, err;

  modport master (
    output key_up, key_down, key_left, key_right, key_ok,
    input  cursor_x, cursor_y, input_val, result, op_char, calc_done, busy, err
  );

  modport slave (
    input  key_up, key_down, key_left, key_right, key_ok,
    output cursor_x, cursor_y, input_val, result, op_char, calc_done, busy, err
  );
endinterface

// File: rtl/calc_seq_arith.sv
// Multi-cycle shift-add multiplier; with CALC_DIV_EN also a restoring divider
// (two quotient bits per cycle). Both finish in exactly OPB_W cycles after start.
module calc_seq_arith #(
  parameter int DW    = 16,
  parameter int OPB_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_op,
  input  logic [DW-1:0]    i_a,
  input  logic [OPB_W-1:0] i_b,
  output logic             o_done,
  output logic [DW-1:0]    o_q,
  output logic             o_sat
);
  localparam int PW = DW + OPB_W;
  localparam int CW = $clog2(OPB_W + 1);

  logic          r_run, r_op;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_acc, r_mcand, w_acc_nx;
  logic [OPB_W-1:0] r_mplier;
  logic [DW-1:0] w_mul_q;
  logic          w_mul_sat;

  // o_done marks the edge on which the final iteration lands, so o_q is the combinational next value.
  assign o_done    = r_run && (r_cnt == CW'(OPB_W - 1));
  assign w_acc_nx  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_sat = |w_acc_nx[PW-1:DW];
  assign w_mul_q   = w_mul_sat ? '1 : w_acc_nx[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_op  <= 1'b0;
    end else if (i_abort) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_op  <= i_op;
    end else if (r_run) begin
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_run <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= PW'(i_a);
      r_mplier <= i_b;
    end else if (r_run) begin
      r_acc    <= w_acc_nx;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

`ifdef CALC_DIV_EN
  localparam int DVW = 2 * OPB_W;

  logic [DVW-1:0]   r_dvd, r_quo, w_dvd_nx, w_quo_nx;
  logic [OPB_W-1:0] r_rem, r_dvs, w_rem_nx;
  logic [OPB_W:0]   w_rt;
  logic [DVW-DW-1:0] w_unused_quo;

  always_comb begin
    w_dvd_nx = r_dvd;
    w_quo_nx = r_quo;
    w_rem_nx = r_rem;
    w_rt     = '0;
    for (int i = 0; i < 2; i++) begin
      w_rt     = {w_rem_nx, w_dvd_nx[DVW-1]};
      w_dvd_nx = w_dvd_nx << 1;
      if (w_rt >= {1'b0, r_dvs}) begin
        w_rt     = w_rt - {1'b0, r_dvs};
        w_quo_nx = {w_quo_nx[DVW-2:0], 1'b1};
      end else begin
        w_quo_nx = {w_quo_nx[DVW-2:0], 1'b0};
      end
      w_rem_nx = w_rt[OPB_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (i_start) begin
      r_dvd <= DVW'(i_a);
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= i_b;
    end else if (r_run) begin
      r_dvd <= w_dvd_nx;
      r_quo <= w_quo_nx;
      r_rem <= w_rem_nx;
    end
  end

  assign w_unused_quo = w_quo_nx[DVW-1:DW];
  assign o_q   = r_op ? w_quo_nx[DW-1:0] : w_mul_q;
  assign o_sat = !r_op && w_mul_sat;
`else
  logic w_unused_op;
  assign w_unused_op = r_op ^ i_op;
  assign o_q   = w_mul_q;
  assign o_sat = w_mul_sat;
`endif

endmodule

// File: rtl/calc_core.sv
// Calculator engine: cursor, operand entry, operator FSM and result registers.
// Optional divide on the blank key is enabled by defining CALC_DIV_EN.
module calc_core
  import calc_pkg::*;
#(
  parameter int DW      = 16,
  parameter int MAX_DIG = 3,
  parameter int OPB_W   = 10
) (
  input  logic   clk_in,
  input  logic   sys_rst_n,
  calc_if.slave  bus
);
  localparam logic [15:0] DIG_LIM = 16'(10 ** (MAX_DIG - 1));

  state_e        r_state, w_state_nx;
  logic [1:0]    r_cx, r_cy;
  logic [DW-1:0] r_a, r_res, w_a_nx, w_res_nx, w_b;
  logic [15:0]   r_in, w_in_nx;
  logic [7:0]    r_op, w_op_nx;
  logic          r_done, r_busy, r_err, w_done_nx, w_busy_nx, w_err_nx;
  logic [DW:0]   w_sum;
  key_e          w_key;
  logic          w_is_op, w_seq_start, w_seq_div, w_abort, w_seq_done, w_seq_sat;
  logic [DW-1:0] w_seq_q;

  assign w_key = key_at(r_cy, r_cx);
  assign w_b   = DW'(r_in);
  assign w_sum = {1'b0, r_a} + {1'b0, w_b};
`ifdef CALC_DIV_EN
  assign w_is_op = (w_key == K_ADD) || (w_key == K_SUB) || (w_key == K_MUL) || (w_key == K_BLANK);
`else
  assign w_is_op = (w_key == K_ADD) || (w_key == K_SUB) || (w_key == K_MUL);
`endif

  calc_seq_arith #(.DW(DW), .OPB_W(OPB_W)) u_seq (
    .clk     (clk_in),
    .rst_n   (sys_rst_n),
    .i_start (w_seq_start),
    .i_abort (w_abort),
    .i_op    (w_seq_div),
    .i_a     (r_a),
    .i_b     (r_in[OPB_W-1:0]),
    .o_done  (w_seq_done),
    .o_q     (w_seq_q),
    .o_sat   (w_seq_sat)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_a_nx      = r_a;
    w_in_nx     = r_in;
    w_res_nx    = r_res;
    w_op_nx     = r_op;
    w_done_nx   = r_done;
    w_busy_nx   = r_busy;
    w_err_nx    = r_err;
    w_seq_start = 1'b0;
    w_seq_div   = 1'b0;
    w_abort     = 1'b0;
    if (bus.key_ok && w_key == K_CLR) begin
      w_state_nx = S_OPA;
      w_a_nx     = '0;
      w_in_nx    = '0;
      w_res_nx   = '0;
      w_op_nx    = '0;
      w_done_nx  = 1'b0;
      w_busy_nx  = 1'b0;
      w_err_nx   = 1'b0;
      w_abort    = 1'b1;
    end else if (r_state == S_EXEC) begin
      if (w_seq_done) begin
        w_res_nx   = w_seq_q;
        w_err_nx   = w_seq_sat;
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b1;
        w_state_nx = S_DONE;
      end
    end else if (bus.key_ok) begin
      if (w_key <= K_9) begin
        if (r_state == S_DONE) begin
          w_in_nx    = {12'd0, w_key};
          w_done_nx  = 1'b0;
          w_err_nx   = 1'b0;
          w_op_nx    = '0;
          w_state_nx = S_OPA;
        end else if (r_in < DIG_LIM) begin
          w_in_nx = r_in * 16'd10 + {12'd0, w_key};
        end
      end else if (w_is_op) begin
        w_op_nx = key_char(w_key);
        if (r_state == S_OPA) begin
          w_a_nx     = w_b;
          w_in_nx    = '0;
          w_state_nx = S_OPB;
        end else if (r_state == S_DONE) begin
          w_a_nx     = r_res;
          w_in_nx    = '0;
          w_done_nx  = 1'b0;
          w_err_nx   = 1'b0;
          w_state_nx = S_OPB;
        end
      end else if (w_key == K_EQ && r_state == S_OPB) begin
        case (r_op)
          CH_ADD: begin
            w_res_nx   = w_sum[DW] ? '1 : w_sum[DW-1:0];
            w_err_nx   = w_sum[DW];
            w_done_nx  = 1'b1;
            w_state_nx = S_DONE;
          end
          CH_SUB: begin
            w_res_nx   = (w_b > r_a) ? '0 : r_a - w_b;
            w_err_nx   = (w_b > r_a);
            w_done_nx  = 1'b1;
            w_state_nx = S_DONE;
          end
          CH_MUL: begin
            w_seq_start = 1'b1;
            w_busy_nx   = 1'b1;
            w_state_nx  = S_EXEC;
          end
`ifdef CALC_DIV_EN
          CH_DIV: begin
            if (r_in == '0) begin
              w_res_nx   = '0;
              w_err_nx   = 1'b1;
              w_done_nx  = 1'b1;
              w_state_nx = S_DONE;
            end else begin
              w_seq_start = 1'b1;
              w_seq_div   = 1'b1;
              w_busy_nx   = 1'b1;
              w_state_nx  = S_EXEC;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_OPA;
    else            r_state <= w_state_nx;
  end

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_a    <= '0;
      r_in   <= '0;
      r_res  <= '0;
      r_op   <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_a    <= w_a_nx;
      r_in   <= w_in_nx;
      r_res  <= w_res_nx;
      r_op   <= w_op_nx;
      r_done <= w_done_nx;
      r_busy <= w_busy_nx;
      r_err  <= w_err_nx;
    end
  end

  // Cursor moves in every state; only the highest-priority direction applies.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (bus.key_up) begin
      r_cy <= r_cy - 2'd1;
    end else if (bus.key_down) begin
      r_cy <= r_cy + 2'd1;
    end else if (bus.key_left) begin
      r_cx <= r_cx - 2'd1;
    end else if (bus.key_right) begin
      r_cx <= r_cx + 2'd1;
    end
  end

  assign bus.cursor_x  = {2'b00, r_cx};
  assign bus.cursor_y  = {2'b00, r_cy};
  assign bus.input_val = r_in;
  assign bus.result    = r_res;
  assign bus.op_char   = r_op;
  assign bus.calc_done = r_done;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;

endmodule
